pkt_commit_buffer: RTL and testbench
====================================

# pkt_commit_buffer

Store-and-forward packet buffer directly upstream of the deparser. It accepts the parser-side AXI-Stream packet data and presents the fall-through `pkt_fifo_*` read interface that the deparser consumes. A packet becomes visible to the reader only once its last beat is stored. A packet that does not fit is dropped whole, so the deparser never sees a partial packet or stalls on one.

## Interface
- `C_AXIS_DATA_WIDTH`, 256, beat data width.
- `C_AXIS_TUSER_WIDTH`, 128, beat tuser width.
- `DEPTH_BITS`, 6, log2 of buffer depth in beats (capacity 2^DEPTH_BITS).

Ports:
- `axis_clk` in 1: the single clock.
- `aresetn` in 1: reset, synchronous, active-low.
- `s_axis_tdata` in C_AXIS_DATA_WIDTH: input beat data.
- `s_axis_tkeep` in C_AXIS_DATA_WIDTH/8: byte enables.
- `s_axis_tuser` in C_AXIS_TUSER_WIDTH: metadata; meaningful on the first beat and stored on every beat.
- `s_axis_tvalid` in 1: beat valid.
- `s_axis_tlast` in 1: last beat of packet.
- `s_axis_tready` out 1: constant 1. The block drops instead of back-pressuring.
- `pkt_fifo_tdata` out C_AXIS_DATA_WIDTH: head beat data.
- `pkt_fifo_tkeep` out C_AXIS_DATA_WIDTH/8: head beat tkeep.
- `pkt_fifo_tuser` out C_AXIS_TUSER_WIDTH: head beat tuser.
- `pkt_fifo_tlast` out 1: head beat tlast.
- `pkt_fifo_empty` out 1: no committed beat available.
- `pkt_fifo_rd_en` in 1: pop the head beat.

## Operation
- Storage: 2^DEPTH_BITS entries, each entry {tdata, tuser, tkeep, tlast}.
- Pointers `wr_ptr`, `commit_ptr` and `rd_ptr` are each DEPTH_BITS+1 bits. The extra bit is the wrap bit.
- Occupancy is `wr_ptr - rd_ptr` (mod 2^(DEPTH_BITS+1)).
- `full` is occupancy == 2^DEPTH_BITS, evaluated on registered pointers.
- A read in the same cycle does not free space for a write in that cycle.
- Write FSM, states IDLE, WRITE, DROP:
  - IDLE, beat accepted, not full: store at `wr_ptr`, then `wr_ptr++`. If tlast, `commit_ptr <= wr_ptr+1` and stay in IDLE; otherwise go to WRITE.
  - WRITE, beat accepted, not full: store, then `wr_ptr++`. If tlast, commit and go to IDLE.
  - IDLE or WRITE, beat accepted while full: no store, `wr_ptr <= commit_ptr` (rollback), count a drop. If tlast, go to IDLE; otherwise go to DROP.
  - DROP: discard beats. On tlast, go to IDLE.
- Packets longer than 2^DEPTH_BITS beats are always dropped.
- Read side:
  - `pkt_fifo_empty = (rd_ptr == commit_ptr)`.
  - `pkt_fifo_*` data is combinational from `mem[rd_ptr[DEPTH_BITS-1:0]]`.
  - `pkt_fifo_rd_en` while not empty: `rd_ptr++`.
  - `pkt_fifo_rd_en` while empty: ignored.
- Simultaneous commit and read: both pointers update. `pkt_fifo_empty` is recomputed from the new values the next cycle.

## Timing
- Reset (`aresetn`=0 at a clock edge):
  - All pointers go to 0 and the FSM to IDLE.
  - `pkt_fifo_empty`=1 and `s_axis_tready`=1.
  - `pkt_fifo_*` data outputs are don't-care while empty.
  - Memory contents are not cleared.
  - Reset mid-packet discards all stored and partial packets. Beats that arrive after reset without a preceding packet start are treated as a new packet.
- Latency: `pkt_fifo_empty` deasserts on the cycle after the tlast beat is accepted. Minimum cut-through latency is packet length + 1 cycles.
- `pkt_fifo_rd_en` takes effect at the clock edge; the next head beat is visible in the following cycle.
- `drop_cnt` and `pkt_cnt` update one cycle after the triggering beat.

## Configuration
- `PKT_BUF_STATS_EN` defined:
  - Adds outputs `drop_cnt` (out 32: packets dropped) and `pkt_cnt` (out 32: packets committed).
  - Both counters wrap, and both reset to 0.
  - A drop is counted once per packet, on the cycle the rollback occurs.
- `PKT_BUF_STATS_EN` undefined: these ports and counters are absent. Datapath behaviour is identical.

## Test plan
- 3-beat packet, tuser=0x5A on beat 0, no reads:
  - `pkt_fifo_empty` falls one cycle after the tlast beat.
  - Three pops return the beats in order with tuser 0x5A, and tlast only on the third.
  - Empty reasserts after the third pop.
- DEPTH_BITS=3, no reads, 6-beat packet then 4-beat packet:
  - The second packet rolls back and `drop_cnt`=1, `pkt_cnt`=1.
  - Exactly 6 beats are readable.
  - A following 2-beat packet is stored.
- DEPTH_BITS=3, 9-beat packet into an empty buffer:
  - Dropped, buffer remains empty, `drop_cnt`=1.
  - A subsequent 8-beat packet commits.
- Buffer full, simultaneous pop and new 1-beat tlast packet:
  - The write is dropped (no same-cycle credit).
  - The next 1-beat packet is accepted.
- `pkt_fifo_rd_en` held high while empty for 10 cycles, then a 1-beat packet arrives:
  - `rd_ptr` is unchanged until the commit.
  - The beat is popped the cycle after empty falls.
- `aresetn` pulsed low during beat 2 of a 5-beat packet with one committed packet stored:
  - `pkt_fifo_empty`=1 the cycle after reset.
  - The remaining beats 3–5 are stored as a new 3-beat packet.

Source files
------------

// File: rtl/pkt_commit_buffer.sv
// pkt_commit_buffer
//   Store-and-forward packet buffer feeding the deparser. Beats from the
//   parser-side AXI-Stream are written into a circular buffer. A packet is
//   visible on the fall-through pkt_fifo_* read port only once its last beat
//   has been stored. A packet that does not fit is rolled back and dropped
//   whole. The block never back-pressures, so s_axis_tready is tied to 1.
//
// Ports
//   axis_clk        clock
//   aresetn         synchronous active-low reset
//   s_axis_tdata    input beat data                 [C_AXIS_DATA_WIDTH]
//   s_axis_tkeep    input byte enables              [C_AXIS_DATA_WIDTH/8]
//   s_axis_tuser    input metadata                  [C_AXIS_TUSER_WIDTH]
//   s_axis_tvalid   input beat valid
//   s_axis_tlast    input last beat of packet
//   s_axis_tready   always 1
//   pkt_fifo_tdata  head beat data (combinational from buffer head)
//   pkt_fifo_tkeep  head beat tkeep
//   pkt_fifo_tuser  head beat tuser
//   pkt_fifo_tlast  head beat tlast
//   pkt_fifo_empty  no committed beat available
//   pkt_fifo_rd_en  pop the head beat (ignored while empty)
//   drop_cnt        packets dropped   (only with PKT_BUF_STATS_EN)
//   pkt_cnt         packets committed (only with PKT_BUF_STATS_EN)
//
// Build option
//   PKT_BUF_STATS_EN : adds the wrapping drop_cnt / pkt_cnt statistics outputs.

module pkt_commit_buffer #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int DEPTH_BITS         = 6
) (
  input  logic                            axis_clk,
  input  logic                            aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    pkt_fifo_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  pkt_fifo_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   pkt_fifo_tuser,
  output logic                            pkt_fifo_tlast,
  output logic                            pkt_fifo_empty,
  input  logic                            pkt_fifo_rd_en
`ifdef PKT_BUF_STATS_EN
  ,
  output logic [31:0]                     drop_cnt,
  output logic [31:0]                     pkt_cnt
`endif
);

  localparam int          KEEP_W  = C_AXIS_DATA_WIDTH / 8;
  localparam int          ENTRY_W = C_AXIS_DATA_WIDTH + C_AXIS_TUSER_WIDTH + KEEP_W + 1;
  localparam int unsigned DEPTH   = 1 << DEPTH_BITS;

  typedef logic [DEPTH_BITS:0] ptr_t;

  // Occupancy value meaning "every entry in use"; the extra pointer bit
  // distinguishes this from empty.
  localparam ptr_t CAP = {1'b1, {DEPTH_BITS{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DROP
  } state_e;

  state_e state_q, state_d;
  ptr_t   wr_q, wr_d;
  ptr_t   commit_q, commit_d;
  ptr_t   rd_q, rd_d;
  logic   mem_we;
  logic   full;
  logic   empty;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] rd_entry;

`ifdef PKT_BUF_STATS_EN
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
`endif

  assign s_axis_tready = 1'b1;

  // Occupancy includes the uncommitted beats of the packet being written.
  // Only registered pointers are used, so a same-cycle pop gives no credit.
  assign full  = ((wr_q - rd_q) == CAP);
  assign empty = (rd_q == commit_q);

  assign pkt_fifo_empty = empty;
  assign rd_entry       = mem_q[rd_q[DEPTH_BITS-1:0]];
  assign {pkt_fifo_tdata, pkt_fifo_tuser, pkt_fifo_tkeep, pkt_fifo_tlast} = rd_entry;

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    commit_d = commit_q;
    rd_d     = rd_q;
    mem_we   = 1'b0;
`ifdef PKT_BUF_STATS_EN
    drop_cnt_d = drop_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
`endif

    if (s_axis_tvalid) begin
      case (state_q)
        IDLE, WRITE: begin
          if (!full) begin
            mem_we = 1'b1;
            wr_d   = wr_q + ptr_t'(1);
            if (s_axis_tlast) begin
              commit_d = wr_q + ptr_t'(1);
              state_d  = IDLE;
`ifdef PKT_BUF_STATS_EN
              pkt_cnt_d = pkt_cnt_q + 32'd1;
`endif
            end else begin
              state_d = WRITE;
            end
          end else begin
            // Rewind over the partial packet; the rest of it is discarded in DROP.
            wr_d    = commit_q;
            state_d = s_axis_tlast ? IDLE : DROP;
`ifdef PKT_BUF_STATS_EN
            drop_cnt_d = drop_cnt_q + 32'd1;
`endif
          end
        end
        DROP: begin
          if (s_axis_tlast) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (pkt_fifo_rd_en && !empty) begin
      rd_d = rd_q + ptr_t'(1);
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      wr_q     <= '0;
      commit_q <= '0;
      rd_q     <= '0;
`ifdef PKT_BUF_STATS_EN
      drop_cnt_q <= '0;
      pkt_cnt_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      commit_q <= commit_d;
      rd_q     <= rd_d;
`ifdef PKT_BUF_STATS_EN
      drop_cnt_q <= drop_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
`endif
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge axis_clk) begin
    if (mem_we) begin
      mem_q[wr_q[DEPTH_BITS-1:0]] <= {s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast};
    end
  end

`ifdef PKT_BUF_STATS_EN
  assign drop_cnt = drop_cnt_q;
  assign pkt_cnt  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_commit_buffer.sv
// Self-checking bench for pkt_commit_buffer with an 8-entry buffer.
// Beats of packets expected to commit are queued when driven and compared
// against the head of the read port as they are popped.

module tb_pkt_commit_buffer;

  localparam int DW = 64;
  localparam int UW = 16;
  localparam int KW = DW / 8;
  localparam int DB = 3;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic [UW-1:0] s_tuser;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [DW-1:0] f_tdata;
  logic [KW-1:0] f_tkeep;
  logic [UW-1:0] f_tuser;
  logic          f_tlast;
  logic          f_empty;
  logic          rd_en;
`ifdef PKT_BUF_STATS_EN
  logic [31:0]   drop_cnt;
  logic [31:0]   pkt_cnt;
`endif

  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_drop = 0;
  int    exp_pkt  = 0;

  always #5 clk = ~clk;

  pkt_commit_buffer #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW),
    .DEPTH_BITS        (DB)
  ) dut (
    .axis_clk      (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .pkt_fifo_tdata(f_tdata),
    .pkt_fifo_tkeep(f_tkeep),
    .pkt_fifo_tuser(f_tuser),
    .pkt_fifo_tlast(f_tlast),
    .pkt_fifo_empty(f_empty),
    .pkt_fifo_rd_en(rd_en)
`ifdef PKT_BUF_STATS_EN
    ,
    .drop_cnt      (drop_cnt),
    .pkt_cnt       (pkt_cnt)
`endif
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    sb.delete();
    exp_drop = 0;
    exp_pkt  = 0;
  endtask

  // Drives one packet, one beat per cycle; e_pre is empty as seen just
  // before the tlast beat is clocked in.
  task automatic send_pkt(input int len, input logic [UW-1:0] u, input bit commit,
                          output logic e_pre);
    e_pre = 1'b0;
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.d = {$urandom, $urandom};
      b.u = u;
      b.k = KW'($urandom);
      b.l = (i == len - 1);
      s_tdata  = b.d;
      s_tuser  = b.u;
      s_tkeep  = b.k;
      s_tlast  = b.l;
      s_tvalid = 1'b1;
      if (commit) sb.push_back(b);
      if (i == len - 1) e_pre = f_empty;
      step();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (commit) exp_pkt++;
  endtask

  task automatic pop_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      beat_t got, exp;
      got = {f_tdata, f_tuser, f_tkeep, f_tlast};
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL %s beat %0d: nothing expected, got empty=%b data=%h", tag, i, f_empty, got);
      end else begin
        exp = sb.pop_front();
        if (f_empty !== 1'b0 || got !== exp) begin
          n_fail++;
          $display("FAIL %s beat %0d: got empty=%b entry=%h, expected empty=0 entry=%h",
                   tag, i, f_empty, got, exp);
        end
      end
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    step();
    step();
    n_checks++;
    if (f_empty !== 1'b1 || s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: got empty=%b tready=%b, expected 1/1", f_empty, s_tready);
    end
`ifdef PKT_BUF_STATS_EN
    n_checks++;
    if (drop_cnt !== 32'd0 || pkt_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got drop=%0d pkt=%0d, expected 0/0", drop_cnt, pkt_cnt);
    end
`endif
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic e;
    send_pkt(3, 16'h005A, 1'b1, e);
    n_checks++;
    if (e !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_pre_last: got empty=%b, expected 1", e);
    end
    n_checks++;
    if (f_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after_last: got empty=%b, expected 0", f_empty);
    end
    pop_check(3, "basic");
    n_checks++;
    if (f_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_drained: got empty=%b, expected 1", f_empty);
    end
  endtask

  task automatic test_overflow();
    logic e;
    do_reset();
    send_pkt(6, 16'h0101, 1'b1, e);
    send_pkt(4, 16'h0202, 1'b0, e);
    exp_drop++;
`ifdef PKT_BUF_STATS_EN
    n_checks++;
    if (drop_cnt !== 32'(exp_drop) || pkt_cnt !== 32'(exp_pkt)) begin
      n_fail++;
      $display("FAIL overflow_cnt: got drop=%0d pkt=%0d, expected %0d/%0d",
               drop_cnt, pkt_cnt, exp_drop, exp_pkt);
    end
`endif
    pop_check(6, "overflow_first");
    n_checks++;
    if (f_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_six_only: got empty=%b, expected 1", f_empty);
    end
    send_pkt(2, 16'h0303, 1'b1, e);
    pop_check(2, "overflow_after");
  endtask

  task automatic test_oversize();
    logic e;
    do_reset();
    send_pkt(9, 16'h0909, 1'b0, e);
    exp_drop++;
    n_checks++;
    if (e !== 1'b1 || f_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL oversize_empty: got pre=%b post=%b, expected 1/1", e, f_empty);
    end
`ifdef PKT_BUF_STATS_EN
    n_checks++;
    if (drop_cnt !== 32'(exp_drop)) begin
      n_fail++;
      $display("FAIL oversize_drop: got %0d, expected %0d", drop_cnt, exp_drop);
    end
`endif
    send_pkt(8, 16'h0808, 1'b1, e);
    pop_check(8, "oversize_follow");
    n_checks++;
    if (f_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL oversize_drained: got empty=%b, expected 1", f_empty);
    end
  endtask

  task automatic test_full_race();
    logic  e;
    beat_t got, exp;
    send_pkt(8, 16'h0777, 1'b1, e);
    // Buffer is full: pop the head and offer a 1-beat packet in the same cycle.
    got = {f_tdata, f_tuser, f_tkeep, f_tlast};
    exp = sb.pop_front();
    n_checks++;
    if (f_empty !== 1'b0 || got !== exp) begin
      n_fail++;
      $display("FAIL race_head: got empty=%b entry=%h, expected empty=0 entry=%h",
               f_empty, got, exp);
    end
    rd_en    = 1'b1;
    s_tdata  = {$urandom, $urandom};
    s_tuser  = 16'hDEAD;
    s_tkeep  = '1;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    step();
    rd_en    = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    exp_drop++;
`ifdef PKT_BUF_STATS_EN
    n_checks++;
    if (drop_cnt !== 32'(exp_drop)) begin
      n_fail++;
      $display("FAIL race_drop: got %0d, expected %0d", drop_cnt, exp_drop);
    end
`endif
    send_pkt(1, 16'h0778, 1'b1, e);
    pop_check(8, "race_rest");
    n_checks++;
    if (f_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL race_drained: got empty=%b, expected 1", f_empty);
    end
  endtask

  task automatic test_rd_while_empty();
    logic  e;
    beat_t got, exp;
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (f_empty !== 1'b1) begin
        n_fail++;
        $display("FAIL rd_empty cycle %0d: got empty=%b, expected 1", i, f_empty);
      end
      step();
    end
    send_pkt(1, 16'h0A0A, 1'b1, e);
    got = {f_tdata, f_tuser, f_tkeep, f_tlast};
    exp = sb.pop_front();
    n_checks++;
    if (e !== 1'b1 || f_empty !== 1'b0 || got !== exp) begin
      n_fail++;
      $display("FAIL rd_empty_commit: got pre=%b empty=%b entry=%h, expected 1/0 entry=%h",
               e, f_empty, got, exp);
    end
    step();
    rd_en = 1'b0;
    n_checks++;
    if (f_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_empty_popped: got empty=%b, expected 1", f_empty);
    end
  endtask

  task automatic test_reset_midpacket();
    logic e;
    send_pkt(2, 16'h0B0B, 1'b1, e);
    s_tuser  = 16'h0C0C;
    s_tkeep  = '1;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = {$urandom, $urandom};
    step();
    s_tdata  = {$urandom, $urandom};
    aresetn  = 1'b0;
    step();
    aresetn  = 1'b1;
    s_tvalid = 1'b0;
    sb.delete();
    exp_drop = 0;
    exp_pkt  = 0;
    n_checks++;
    if (f_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_empty: got empty=%b, expected 1", f_empty);
    end
    send_pkt(3, 16'h0C0C, 1'b1, e);
`ifdef PKT_BUF_STATS_EN
    n_checks++;
    if (drop_cnt !== 32'(exp_drop) || pkt_cnt !== 32'(exp_pkt)) begin
      n_fail++;
      $display("FAIL midreset_cnt: got drop=%0d pkt=%0d, expected %0d/%0d",
               drop_cnt, pkt_cnt, exp_drop, exp_pkt);
    end
`endif
    pop_check(3, "midreset_tail");
    n_checks++;
    if (f_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_drained: got empty=%b, expected 1", f_empty);
    end
  endtask

  initial begin
    aresetn  = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tuser  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    rd_en    = 1'b0;
    step();
    test_reset();
    test_basic();
    test_overflow();
    test_oversize();
    test_full_race();
    test_rd_while_empty();
    test_reset_midpacket();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

endmodule
